// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//
// Receives the PS/2 keyboard stream that the MiST user_io bridge produces.
// It turns set-2 scancodes into one-cycle key events that carry the
// extended (E0) and break (F0) qualifiers.
//
// The block runs on the fast core clock. Both PS/2 lines are oversampled
// through synchronisers, and falling edges of the synchronised ps2_clk
// drive a small IDLE/RECV/CHECK state machine.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   : a frame with an even number of ones across its data and
//               parity bits is dropped and reported on frame_error.
//   undefined : the parity bit is received but ignored.
//
// Parameters
//   TIMEOUT_CYCLES : clk cycles without a ps2_clk fall before a partial
//                    frame is discarded (must stay below 8192)
//   SYNC_STAGES    : synchroniser depth on both PS/2 lines (2..3)
//
// Ports
//   clk          in   core clock, rising edge
//   reset        in   synchronous, active-high
//   ps2_clk      in   PS/2 clock, asynchronous, idles high
//   ps2_data     in   PS/2 data, asynchronous
//   rx_byte      out  last raw byte received, including prefix bytes
//   rx_valid     out  one-cycle pulse when rx_byte is updated
//   key_code     out  scancode of the last key event
//   key_extended out  last key event was preceded by E0
//   key_released out  last key event was preceded by F0
//   key_strobe   out  one-cycle pulse when the key_* outputs are updated
//   frame_error  out  one-cycle pulse on bad start/stop/parity or timeout

module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_strobe,
  output logic       frame_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } stateT;

  localparam logic [12:0] TIMEOUT_VAL = 13'(TIMEOUT_CYCLES);
  localparam logic [12:0] TIMER_MAX   = 13'h1FFF;

  logic [SYNC_STAGES-1:0] clkSync_q;
  logic [SYNC_STAGES-1:0] dataSync_q;
  logic                   clkPrev_q;
  logic                   clkSynced;
  logic                   dataSynced;
  logic                   fall;

  stateT       state_q;
  logic [3:0]  bitCnt_q;
  logic [12:0] timer_q;
  logic [9:0]  shiftReg_q;
  logic [9:0]  shiftReg_d;
  logic        extPend_q;
  logic        brkPend_q;
  logic        parityOk;

  logic [7:0]  rxByte_q;
  logic        rxValid_q;
  logic [7:0]  keyCode_q;
  logic        keyExtended_q;
  logic        keyReleased_q;
  logic        keyStrobe_q;
  logic        frameError_q;

  // Both lines pass through synchronisers of the same depth, so the data
  // bit stays aligned with the clock edge that qualifies it. The stages
  // reset to the idle-high level, so leaving reset never looks like a
  // falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkSync_q  <= '1;
      dataSync_q <= '1;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk};
      dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data};
      clkPrev_q  <= clkSync_q[SYNC_STAGES-1];
    end
  end

  // A falling edge is a synchronised high-to-low transition on ps2_clk.
  // Frames arrive LSB first, so each new bit enters at the top of the
  // shift register. After ten shifts the register holds
  // {stop, parity, data[7:0]}.
  always_comb begin
    clkSynced  = clkSync_q[SYNC_STAGES-1];
    dataSynced = dataSync_q[SYNC_STAGES-1];
    fall       = clkPrev_q & ~clkSynced;
    shiftReg_d = {dataSynced, shiftReg_q[9:1]};
  end

  // Odd parity: data plus parity must hold an odd number of ones.
  // When the check is compiled out, the parity bit is still reduced into
  // the result, but the result is forced true.
`ifdef PS2_PARITY_CHECK_EN
  assign parityOk = ^shiftReg_q[8:0];
`else
  assign parityOk = (^shiftReg_q[8:0]) | 1'b1;
`endif

  // Main receive state machine. It collects the frame, validates it in a
  // single CHECK cycle and tracks the E0/F0 prefixes. The pulse outputs
  // default low every cycle, so each one lasts exactly one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bitCnt_q      <= 4'd0;
      timer_q       <= 13'd0;
      shiftReg_q    <= 10'd0;
      extPend_q     <= 1'b0;
      brkPend_q     <= 1'b0;
      rxByte_q      <= 8'd0;
      rxValid_q     <= 1'b0;
      keyCode_q     <= 8'd0;
      keyExtended_q <= 1'b0;
      keyReleased_q <= 1'b0;
      keyStrobe_q   <= 1'b0;
      frameError_q  <= 1'b0;
    end else begin
      rxValid_q    <= 1'b0;
      keyStrobe_q  <= 1'b0;
      frameError_q <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= 13'd0;
          if (fall) begin
            if (!dataSynced) begin
              state_q  <= RECV;
              bitCnt_q <= 4'd1;
            end else begin
              frameError_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (fall) begin
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= bitCnt_q + 4'd1;
            timer_q    <= 13'd0;
            if (bitCnt_q == 4'd10) begin
              state_q <= CHECK;
            end
          end else if (timer_q == TIMEOUT_VAL) begin
            frameError_q <= 1'b1;
            state_q      <= IDLE;
            bitCnt_q     <= 4'd0;
            timer_q      <= 13'd0;
          end else if (timer_q != TIMER_MAX) begin
            timer_q <= timer_q + 13'd1;
          end
        end
        CHECK: begin
          state_q  <= IDLE;
          bitCnt_q <= 4'd0;
          timer_q  <= 13'd0;
          if (!shiftReg_q[9] || !parityOk) begin
            frameError_q <= 1'b1;
          end else begin
            rxByte_q  <= shiftReg_q[7:0];
            rxValid_q <= 1'b1;
            if (shiftReg_q[7:0] == 8'hE0) begin
              extPend_q <= 1'b1;
            end else if (shiftReg_q[7:0] == 8'hF0) begin
              brkPend_q <= 1'b1;
            end else begin
              keyCode_q     <= shiftReg_q[7:0];
              keyExtended_q <= extPend_q;
              keyReleased_q <= brkPend_q;
              keyStrobe_q   <= 1'b1;
              extPend_q     <= 1'b0;
              brkPend_q     <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          bitCnt_q <= 4'd0;
          timer_q  <= 13'd0;
        end
      endcase
    end
  end

  assign rx_byte      = rxByte_q;
  assign rx_valid     = rxValid_q;
  assign key_code     = keyCode_q;
  assign key_extended = keyExtended_q;
  assign key_released = keyReleased_q;
  assign key_strobe   = keyStrobe_q;
  assign frame_error  = frameError_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx
//
// Directed testbench for ps2_keyboard_rx. It drives PS/2 frames bit by bit
// and counts the pulses on the three strobe outputs. It also captures the
// values presented with each pulse and compares them against hand-derived
// expectations.

module tb_ps2_keyboard_rx;

  localparam int TIMEOUT = 4095;
  localparam int SYNC    = 2;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       key_strobe;
  logic       frame_error;

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .key_code(key_code),
    .key_extended(key_extended),
    .key_released(key_released),
    .key_strobe(key_strobe),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  int checkCount = 0;
  int errorCount = 0;

  int rxCount = 0;
  int strobeCount = 0;
  int errCount = 0;
  int lastStrobeCycle = 0;
  logic [7:0] lastRx = 8'd0;
  logic [7:0] lastCode = 8'd0;
  logic lastExt = 1'b0;
  logic lastRel = 1'b0;

  int lastFallCycle = 0;
  int stopFallCycle = 0;
  int rx0, st0, er0;

  // Free-running cycle counter used to measure latency.
  always @(posedge clk) begin
    cycleCnt++;
  end

  // Pulse monitor, sampled on the falling clock edge away from DUT updates.
  always @(negedge clk) begin
    if (rx_valid) begin
      rxCount++;
      lastRx = rx_byte;
    end
    if (key_strobe) begin
      strobeCount++;
      lastCode = key_code;
      lastExt = key_extended;
      lastRel = key_released;
      lastStrobeCycle = cycleCnt;
    end
    if (frame_error) begin
      errCount++;
    end
  end

  // Counts one comparison and reports it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Records the pulse counters so each test can compare against deltas.
  task automatic snap();
    rx0 = rxCount;
    st0 = strobeCount;
    er0 = errCount;
  endtask

  // One PS/2 bit: data set while the clock is high, then a low and a high phase.
  task automatic sendBit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    lastFallCycle = cycleCnt;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame: start, 8 data bits LSB first, odd parity (optionally flipped), stop.
  task automatic applyStimulus(input logic [7:0] d, input logic flipParity,
                               input logic stopBit);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    sendBit((~^d) ^ flipParity);
    sendBit(stopBit);
    stopFallCycle = lastFallCycle;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rx_byte", rx_byte, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_key_code", key_code, 0);
    checkOutput("rst_key_ext", key_extended, 0);
    checkOutput("rst_key_rel", key_released, 0);
    checkOutput("rst_key_strobe", key_strobe, 0);
    checkOutput("rst_frame_error", frame_error, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] plain 1C make code");
    snap();
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkOutput("1c_rx_cnt", rxCount - rx0, 1);
    checkOutput("1c_rx_byte", lastRx, 8'h1C);
    checkOutput("1c_strobe_cnt", strobeCount - st0, 1);
    checkOutput("1c_code", lastCode, 8'h1C);
    checkOutput("1c_ext", lastExt, 0);
    checkOutput("1c_rel", lastRel, 0);
    checkOutput("1c_err_cnt", errCount - er0, 0);
    checkOutput("1c_latency", lastStrobeCycle - stopFallCycle, SYNC + 2);

    $display("[TB] F0 then 1C break code");
    snap();
    applyStimulus(8'hF0, 1'b0, 1'b1);
    checkOutput("f0_rx_cnt", rxCount - rx0, 1);
    checkOutput("f0_rx_byte", lastRx, 8'hF0);
    checkOutput("f0_no_strobe", strobeCount - st0, 0);
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkOutput("f0_1c_strobe_cnt", strobeCount - st0, 1);
    checkOutput("f0_1c_code", lastCode, 8'h1C);
    checkOutput("f0_1c_rel", lastRel, 1);
    checkOutput("f0_1c_ext", lastExt, 0);

    $display("[TB] E0 F0 75 then 1C");
    snap();
    applyStimulus(8'hE0, 1'b0, 1'b1);
    applyStimulus(8'hF0, 1'b0, 1'b1);
    applyStimulus(8'h75, 1'b0, 1'b1);
    checkOutput("e0f075_rx_cnt", rxCount - rx0, 3);
    checkOutput("e0f075_strobe_cnt", strobeCount - st0, 1);
    checkOutput("e0f075_code", lastCode, 8'h75);
    checkOutput("e0f075_ext", lastExt, 1);
    checkOutput("e0f075_rel", lastRel, 1);
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkOutput("after_1c_code", lastCode, 8'h1C);
    checkOutput("after_1c_ext", lastExt, 0);
    checkOutput("after_1c_rel", lastRel, 0);

    $display("[TB] 1C with wrong parity");
    snap();
    applyStimulus(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    checkOutput("par_err_cnt", errCount - er0, 1);
    checkOutput("par_rx_cnt", rxCount - rx0, 0);
    checkOutput("par_strobe_cnt", strobeCount - st0, 0);
`else
    checkOutput("par_err_cnt", errCount - er0, 0);
    checkOutput("par_rx_cnt", rxCount - rx0, 1);
    checkOutput("par_strobe_cnt", strobeCount - st0, 1);
    checkOutput("par_code", lastCode, 8'h1C);
`endif

    $display("[TB] bad start bit");
    snap();
    sendBit(1'b1);
    repeat (10) @(negedge clk);
    checkOutput("start_err_cnt", errCount - er0, 1);
    checkOutput("start_rx_cnt", rxCount - rx0, 0);

    $display("[TB] bad stop bit");
    snap();
    applyStimulus(8'h5A, 1'b0, 1'b0);
    ps2_data = 1'b1;
    checkOutput("stop_err_cnt", errCount - er0, 1);
    checkOutput("stop_rx_cnt", rxCount - rx0, 0);
    checkOutput("stop_strobe_cnt", strobeCount - st0, 0);

    $display("[TB] timeout on partial frame");
    snap();
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(i[0]);
    repeat (TIMEOUT + 5) @(negedge clk);
    checkOutput("tmo_err_cnt", errCount - er0, 1);
    checkOutput("tmo_rx_cnt", rxCount - rx0, 0);
    applyStimulus(8'h29, 1'b0, 1'b1);
    checkOutput("tmo_29_strobe_cnt", strobeCount - st0, 1);
    checkOutput("tmo_29_code", lastCode, 8'h29);
    checkOutput("tmo_29_err_cnt", errCount - er0, 1);

    $display("[TB] reset mid-frame after E0");
    applyStimulus(8'hE0, 1'b0, 1'b1);
    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(i[0]);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_rst_rx_byte", rx_byte, 0);
    checkOutput("mid_rst_key_code", key_code, 0);
    checkOutput("mid_rst_key_ext", key_extended, 0);
    checkOutput("mid_rst_key_rel", key_released, 0);
    reset = 1'b0;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    applyStimulus(8'h75, 1'b0, 1'b1);
    checkOutput("post_rst_strobe_cnt", strobeCount - st0, 1);
    checkOutput("post_rst_code", lastCode, 8'h75);
    checkOutput("post_rst_ext", lastExt, 0);
    checkOutput("post_rst_rel", lastRel, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
